// File: rtl/vga_rect_engine_pkg.sv
// Shared definitions for the rectangle engine: resolution tables, command modes
// and FSM state encoding.
package vga_rect_engine_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_CLEAR   = 2'b01;
    localparam logic [1:0] MODE_OUTLINE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Resolution strings are always 7 characters, e.g. "320x240".
    function automatic int res_x_max(input logic [55:0] res);
        case (res)
            "320x240": return 320;
            "160x120": return 160;
            default:   return 640;
        endcase
    endfunction

    function automatic int res_y_max(input logic [55:0] res);
        case (res)
            "320x240": return 240;
            "160x120": return 120;
            default:   return 480;
        endcase
    endfunction

    function automatic int res_nx(input logic [55:0] res);
        case (res)
            "320x240": return 9;
            "160x120": return 8;
            default:   return 10;
        endcase
    endfunction

    function automatic int res_ny(input logic [55:0] res);
        case (res)
            "320x240": return 8;
            "160x120": return 7;
            default:   return 9;
        endcase
    endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry an extra wrap bit.
module vga_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vga_rect_engine.sv
// Rectangle engine: queued commands are clipped and rastered into one pixel write
// per clock. Define VGA_RECT_OUTLINE_EN to make mode 10 draw outlines only.
module vga_rect_engine
    import vga_rect_engine_pkg::*;
#(
    parameter logic [55:0] RESOLUTION  = "640x480",
    parameter int          COLOR_DEPTH = 9,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          nX          = res_nx(RESOLUTION),
    parameter int          nY          = res_ny(RESOLUTION)
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   bg_done,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_mode,
    input  logic [nX-1:0]          cmd_x,
    input  logic [nY-1:0]          cmd_y,
    input  logic [nX-1:0]          cmd_w,
    input  logic [nY-1:0]          cmd_h,
    input  logic [COLOR_DEPTH-1:0] cmd_color,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    localparam int          X_MAX  = res_x_max(RESOLUTION);
    localparam int          Y_MAX  = res_y_max(RESOLUTION);
    localparam int          CMD_W  = 2 + 2 * nX + 2 * nY + COLOR_DEPTH;
    localparam logic [nX:0] X_LAST = (nX + 1)'(X_MAX - 1);
    localparam logic [nY:0] Y_LAST = (nY + 1)'(Y_MAX - 1);

    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CMD_W-1:0]       fifo_wdata, fifo_rdata;
    logic [1:0]             head_mode;
    logic [nX-1:0]          head_x, head_w;
    logic [nY-1:0]          head_y, head_h;
    logic [COLOR_DEPTH-1:0] head_color;

    assign fifo_push  = cmd_valid & ~fifo_full;
    assign fifo_wdata = {cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
    assign {head_mode, head_x, head_y, head_w, head_h, head_color} = fifo_rdata;
    assign cmd_ready  = resetn & ~fifo_full;

    vga_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [nX-1:0]          cx_q, cx_d, cw_q, cw_d;
    logic [nY-1:0]          cy_q, cy_d, ch_q, ch_d;
    logic [nX-1:0]          xs_q, xs_d, xe_q, xe_d, x_q, x_d;
    logic [nY-1:0]          ys_q, ys_d, ye_q, ye_d, y_q, y_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    logic                   write_q, write_d, done_q, done_d;

    logic                   load_clear, load_empty;
    logic [nX:0]            x_end_raw;
    logic [nY:0]            y_end_raw;
    logic [nX-1:0]          load_xs, load_xe;
    logic [nY-1:0]          load_ys, load_ye;

    // Clipped drawing window of the latched command; sums carry one spare bit.
    always_comb begin
        case (mode_q)
            MODE_CLEAR:              load_clear = 1'b1;
            MODE_FILL, MODE_OUTLINE: load_clear = 1'b0;
            default:                 load_clear = 1'b0;
        endcase
        x_end_raw = {1'b0, cx_q} + {1'b0, cw_q} - (nX + 1)'(1);
        y_end_raw = {1'b0, cy_q} + {1'b0, ch_q} - (nY + 1)'(1);
        if (load_clear) begin
            load_xs    = '0;
            load_ys    = '0;
            load_xe    = X_LAST[nX-1:0];
            load_ye    = Y_LAST[nY-1:0];
            load_empty = 1'b0;
        end else begin
            load_xs    = cx_q;
            load_ys    = cy_q;
            load_xe    = (x_end_raw > X_LAST) ? X_LAST[nX-1:0] : x_end_raw[nX-1:0];
            load_ye    = (y_end_raw > Y_LAST) ? Y_LAST[nY-1:0] : y_end_raw[nY-1:0];
            load_empty = (cw_q == '0) || (ch_q == '0) ||
                         ({1'b0, cx_q} > X_LAST) || ({1'b0, cy_q} > Y_LAST);
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        cw_d     = cw_q;
        ch_d     = ch_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        write_d  = 1'b0;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bg_done && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    mode_d   = head_mode;
                    cx_d     = head_x;
                    cy_d     = head_y;
                    cw_d     = head_w;
                    ch_d     = head_h;
                    color_d  = head_color;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                xs_d = load_xs;
                ys_d = load_ys;
                xe_d = load_xe;
                ye_d = load_ye;
                x_d  = load_xs;
                y_d  = load_ys;
                if (load_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    // The first pixel is a corner, so it is written in every mode.
                    state_d = ST_DRAW;
                    write_d = 1'b1;
                end
            end
            ST_DRAW: begin
                if (x_q == xe_q && y_q == ye_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (x_q == xe_q) begin
                        x_d = xs_q;
                        y_d = y_q + nY'(1);
                    end else begin
                        x_d = x_q + nX'(1);
                    end
`ifdef VGA_RECT_OUTLINE_EN
                    write_d = (mode_q != MODE_OUTLINE) ||
                              (x_d == xs_q) || (x_d == xe_q) ||
                              (y_d == ys_q) || (y_d == ye_q);
`else
                    write_d = 1'b1;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cw_q    <= '0;
            ch_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cw_q    <= cw_d;
            ch_q    <= ch_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            write_q <= write_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign write = write_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Bench for vga_rect_engine at 160x120: randomized rectangles checked against a
// raster-list reference model.
`timescale 1ns/1ps
module tb_vga_rect_engine;

    localparam int NX = 8;
    localparam int NY = 7;
    localparam int CD = 9;
    localparam int XM = 160;
    localparam int YM = 120;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          bg_done = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = '0;
    logic [NX-1:0] cmd_x = '0;
    logic [NY-1:0] cmd_y = '0;
    logic [NX-1:0] cmd_w = '0;
    logic [NY-1:0] cmd_h = '0;
    logic [CD-1:0] cmd_color = '0;
    logic [NX-1:0] x;
    logic [NY-1:0] y;
    logic [CD-1:0] color;
    logic          write, busy, done;

    vga_rect_engine #(
        .RESOLUTION  ("160x120"),
        .COLOR_DEPTH (CD),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .bg_done   (bg_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .x         (x),
        .y         (y),
        .color     (color),
        .write     (write),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    int obs_x[$], obs_y[$], obs_c[$], obs_cyc[$], done_cyc[$];
    int exp_x[$], exp_y[$], exp_c[$], exp_n[$];
    int oob = 0;

    always @(negedge clk) begin
        if (write === 1'b1) begin
            obs_x.push_back(int'(x));
            obs_y.push_back(int'(y));
            obs_c.push_back(int'(color));
            obs_cyc.push_back(cyc);
            if (int'(x) >= XM || int'(y) >= YM) oob++;
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 5ms", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        obs_x.delete(); obs_y.delete(); obs_c.delete(); obs_cyc.delete(); done_cyc.delete();
        exp_x.delete(); exp_y.delete(); exp_c.delete(); exp_n.delete();
    endtask

    // Reference: every pixel of the clipped rectangle, row by row, left to right.
    task automatic model_add(input int mode, input int cx, input int cy, input int w, input int h, input int c);
        int xs, ys, xe, ye, n;
        bit ol;
        n = 0;
        if (mode == 1) begin
            xs = 0; ys = 0; xe = XM - 1; ye = YM - 1;
        end else begin
            if (w == 0 || h == 0 || cx >= XM || cy >= YM) begin
                exp_n.push_back(0);
                return;
            end
            xs = cx; ys = cy;
            xe = (cx + w - 1 > XM - 1) ? XM - 1 : cx + w - 1;
            ye = (cy + h - 1 > YM - 1) ? YM - 1 : cy + h - 1;
        end
        ol = 1'b0;
`ifdef VGA_RECT_OUTLINE_EN
        ol = (mode == 2);
`endif
        for (int yy = ys; yy <= ye; yy++) begin
            for (int xx = xs; xx <= xe; xx++) begin
                if (!ol || xx == xs || xx == xe || yy == ys || yy == ye) begin
                    exp_x.push_back(xx); exp_y.push_back(yy); exp_c.push_back(c);
                    n++;
                end
            end
        end
        exp_n.push_back(n);
    endtask

    task automatic push_cmd(input int mode, input int cx, input int cy, input int w, input int h,
                            input int c, output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        cmd_mode = 2'(mode); cmd_x = NX'(cx); cmd_y = NY'(cy);
        cmd_w = NX'(w); cmd_h = NY'(h); cmd_color = CD'(c);
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, waited);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        model_add(mode, cx, cy, w, h, c);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", tag, busy, k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({write, done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: write/done/busy=%b want 000", {write, done, busy});
        end
        n_cmp++;
        if (x !== '0 || y !== '0 || color !== '0) begin
            n_fail++;
            $display("FAIL reset_pixel: x=%0d y=%0d color=%h want 0 0 0", x, y, color);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%b want 0 while in reset", cmd_ready);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_fill();
        int acc;
        clear_q();
        bg_done = 1'b1;
        push_cmd(0, 10, 20, 3, 2, 'h1C0, acc);
        wait_idle(200, "fill");
        n_cmp++;
        if (obs_x.size() != 6) begin
            n_fail++;
            $display("FAIL fill_count: got %0d writes want 6", obs_x.size());
        end
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
            n_cmp++;
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL fill_pixel[%0d]: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                         i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], exp_c[i]);
            end
        end
        if (obs_cyc.size() == 6) begin
            n_cmp++;
            if (obs_cyc[0] != acc + 2 || obs_cyc[5] != acc + 7) begin
                n_fail++;
                $display("FAIL fill_latency: first/last write at %0d/%0d want %0d/%0d",
                         obs_cyc[0], obs_cyc[5], acc + 2, acc + 7);
            end
        end
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != acc + 8) begin
            n_fail++;
            $display("FAIL fill_done: %0d pulses, first at %0d want 1 pulse at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, acc + 8);
        end
    endtask

    task automatic test_clip();
        int acc;
        clear_q();
        push_cmd(0, 158, 118, 5, 5, int'($urandom_range(0, 511)), acc);
        wait_idle(200, "clip");
        n_cmp++;
        if (obs_x.size() != 4) begin
            n_fail++;
            $display("FAIL clip_count: got %0d writes want 4", obs_x.size());
        end
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
            n_cmp++;
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL clip_pixel[%0d]: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                         i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], exp_c[i]);
            end
        end
        n_cmp++;
        if (oob != 0) begin
            n_fail++;
            $display("FAIL clip_bounds: %0d out-of-range writes want 0", oob);
        end
    endtask

    task automatic test_empty();
        int acc;
        clear_q();
        push_cmd(0, 5, 5, 0, 3, 'h055, acc);
        push_cmd(0, 200, 5, 4, 4, 'h0AA, acc);
        wait_idle(200, "empty");
        n_cmp++;
        if (obs_x.size() != 0 || done_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL empty_cmds: got %0d writes %0d done want 0 writes 2 done",
                     obs_x.size(), done_cyc.size());
        end
    endtask

    task automatic test_back_to_back(input int batch);
        int acc, start;
        clear_q();
        bg_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_cmd(($urandom_range(0, 1) == 1) ? 3 : 0,
                     int'($urandom_range(0, XM - 1)), int'($urandom_range(0, YM - 1)),
                     int'($urandom_range(1, 12)), int'($urandom_range(1, 8)),
                     int'($urandom_range(0, 511)), acc);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b%0d_full: cmd_ready=%b want 0 with 4 queued", batch, cmd_ready);
        end
        cmd_mode = 2'b00; cmd_x = NX'($urandom_range(0, 100)); cmd_y = NY'($urandom_range(0, 100));
        cmd_w = 8'd5; cmd_h = 7'd5; cmd_color = 9'h1FF;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_x.size() != 0 || done_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL b2b%0d_gated: got %0d writes %0d done want 0 0 with bg_done=0",
                     batch, obs_x.size(), done_cyc.size());
        end
        bg_done = 1'b1;
        wait_idle(2000, "b2b");
        n_cmp++;
        if (obs_x.size() != exp_x.size() || done_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL b2b%0d_count: got %0d writes %0d done want %0d writes 4 done",
                     batch, obs_x.size(), done_cyc.size(), exp_x.size());
        end
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
            n_cmp++;
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL b2b%0d_pixel[%0d]: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                         batch, i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], exp_c[i]);
            end
        end
        start = 0;
        for (int k = 0; k < 3; k++) begin
            start += exp_n[k];
            if (start < obs_cyc.size()) begin
                n_cmp++;
                if (obs_cyc[start] - obs_cyc[start - 1] != 4) begin
                    n_fail++;
                    $display("FAIL b2b%0d_gap[%0d]: got %0d cycles between writes want 4",
                             batch, k, obs_cyc[start] - obs_cyc[start - 1]);
                end
            end
        end
    endtask

    task automatic test_clear();
        int acc, bad;
        clear_q();
        bg_done = 1'b1;
        push_cmd(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 'h007, acc);
        wait_idle(20000, "clear");
        n_cmp++;
        if (obs_x.size() != XM * YM) begin
            n_fail++;
            $display("FAIL clear_count: got %0d writes want %0d", obs_x.size(), XM * YM);
        end
        bad = 0;
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++)
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clear_raster: got %0d misplaced pixels want 0", bad);
        end
    endtask

    task automatic test_reset_mid_draw();
        int acc, k;
        clear_q();
        bg_done = 1'b1;
        push_cmd(0, 0, 0, 50, 50, 'h123, acc);
        push_cmd(0, 5, 5, 3, 3, 'h045, acc);
        push_cmd(0, 7, 7, 2, 2, 'h067, acc);
        k = 0;
        while (obs_x.size() < 40 && k < 500) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (obs_x.size() < 40) begin
            n_fail++;
            $display("FAIL middraw_start: got %0d writes want >= 40", obs_x.size());
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL middraw_async: write/busy/done=%b%b%b want 000", write, busy, done);
        end
        repeat (2) @(negedge clk);
        clear_q();
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (obs_x.size() != 0 || done_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL middraw_flush: got %0d writes %0d done after reset want 0 0",
                     obs_x.size(), done_cyc.size());
        end
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL middraw_state: busy=%b cmd_ready=%b want 0 1", busy, cmd_ready);
        end
    endtask

    task automatic test_outline();
        int acc, want_n;
`ifdef VGA_RECT_OUTLINE_EN
        want_n = 10;
`else
        want_n = 12;
`endif
        clear_q();
        bg_done = 1'b1;
        push_cmd(2, 20, 30, 4, 3, int'($urandom_range(0, 511)), acc);
        wait_idle(200, "outline");
        n_cmp++;
        if (obs_x.size() != want_n || obs_x.size() != exp_x.size()) begin
            n_fail++;
            $display("FAIL outline_count: got %0d writes want %0d", obs_x.size(), want_n);
        end
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
            n_cmp++;
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL outline_pixel[%0d]: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                         i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], exp_c[i]);
            end
        end
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != acc + 14) begin
            n_fail++;
            $display("FAIL outline_cycles: %0d done, first at %0d want 1 at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, acc + 14);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_clip();
        test_empty();
        for (int b = 0; b < 3; b++) test_back_to_back(b);
        test_clear();
        test_reset_mid_draw();
        test_outline();
        n_cmp++;
        if (oob != 0) begin
            n_fail++;
            $display("FAIL bounds_overall: %0d out-of-range writes want 0", oob);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
